// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with HI/LO result registers.
// The multiplier is a shift-add engine and the divider is restoring. Both
// run on one 2*WIDTH accumulator and take WIDTH steps. A FIX cycle then
// applies the sign correction and commits the result to HI/LO.
// Optional feature macro: MULDIV_DIV_EN.
//   Defined   : DIV/DIVU (op 10/11) are implemented.
//   Undefined : the divider datapath is compiled out and op[1]=1 starts are ignored.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hilo_rd,
  input  logic             hilo_wr,
  input  logic             hilo_wr_sel,
  input  logic [WIDTH-1:0] hilo_wd,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_accept;
  logic                   w_op_ok;
  logic                   w_fix_commit;
  logic                   w_signed;
  logic [CW-1:0]          r_cnt;
  logic [2*WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]       r_opd;
  logic                   r_neg_res;
  logic [WIDTH-1:0]       r_hi;
  logic [WIDTH-1:0]       r_lo;
  logic                   r_done;
  logic [2*WIDTH-1:0]     w_acc_step;
  logic [2*WIDTH-1:0]     w_prod;
  logic [WIDTH-1:0]       w_res_hi;
  logic [WIDTH-1:0]       w_res_lo;

  // Two's-complement negate of a WIDTH-bit value when neg is set.
  function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  // Two's-complement negate of a 2*WIDTH-bit value when neg is set.
  function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

  // Magnitude of an operand; only signed ops take the absolute value.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    return cneg_w(x, sgn & x[WIDTH-1]);
  endfunction

  // One shift-add step. The multiplier sits in the low half and is consumed LSB first.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] sum;
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? m : {WIDTH{1'b0}})};
    return {sum, acc[WIDTH-1:1]};
  endfunction

`ifdef MULDIV_DIV_EN
  logic r_is_div;
  logic r_neg_rem;

  // One restoring division step. The remainder is in the high half; quotient
  // bits shift into the low half as dividend bits shift out of it.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0]   d);
    logic [WIDTH:0] sh;
    logic [WIDTH:0] diff;
    sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff = sh - {1'b0, d};
    if (sh >= {1'b0, d})
      return {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      return {sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  endfunction

  assign w_op_ok = 1'b1;
`else
  assign w_op_ok = ~op[1];
`endif

  // op[0]=0 selects the signed variants (MULT, DIV).
  assign w_signed     = ~op[0];
  assign w_fix_commit = (r_state == S_FIX) & ~cancel;
  assign busy         = (r_state != S_IDLE);
  assign stall        = busy & (hilo_rd | hilo_wr | start);
  assign done         = r_done;
  assign hi           = r_hi;
  assign lo           = r_lo;

  // Next-state logic: accept in IDLE, iterate in RUN, commit in FIX; cancel aborts.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !cancel && w_op_ok) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (cancel)
          w_state_nxt = S_IDLE;
        else if (r_cnt == '0)
          w_state_nxt = S_FIX;
      end
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Iteration step and FIX-cycle sign correction of the accumulator.
  always_comb begin
    w_acc_step = mul_step(r_acc, r_opd);
    w_prod     = cneg_2w(r_acc, r_neg_res);
    w_res_hi   = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo   = w_prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    if (r_is_div) begin
      w_acc_step = div_step(r_acc, r_opd);
      w_res_lo   = cneg_w(r_acc[WIDTH-1:0], r_neg_res);
      w_res_hi   = cneg_w(r_acc[2*WIDTH-1:WIDTH], r_neg_rem);
    end
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Operand latch, step counter and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opd     <= '0;
      r_neg_res <= 1'b0;
    end else if (w_accept) begin
      r_cnt     <= CW'(WIDTH - 1);
      // A zero divisor keeps an all-ones quotient, so it is never negated.
      r_neg_res <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]) & (b != '0);
      if (op[1]) begin
        r_acc <= {{WIDTH{1'b0}}, mag(a, w_signed)};
        r_opd <= mag(b, w_signed);
      end else begin
        r_acc <= {{WIDTH{1'b0}}, mag(b, w_signed)};
        r_opd <= mag(a, w_signed);
      end
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt - 1'b1;
      r_acc <= w_acc_step;
    end
  end

`ifdef MULDIV_DIV_EN
  // Divide-only flags: operation kind and remainder sign (sign of the dividend).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_div  <= 1'b0;
      r_neg_rem <= 1'b0;
    end else if (w_accept) begin
      r_is_div  <= op[1];
      r_neg_rem <= w_signed & a[WIDTH-1];
    end
  end
`endif

  // HI/LO commit from FIX or MTHI/MTLO in IDLE; done pulses on commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_fix_commit;
      if (w_fix_commit) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else if ((r_state == S_IDLE) && hilo_wr && !cancel && !w_accept) begin
        if (hilo_wr_sel) r_hi <= hilo_wd;
        else             r_lo <= hilo_wd;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32) with an expected-result scoreboard.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cancel = 1'b0;
  logic         hilo_rd = 1'b0;
  logic         hilo_wr = 1'b0;
  logic         hilo_wr_sel = 1'b0;
  logic [W-1:0] hilo_wd = '0;
  logic         busy;
  logic         done;
  logic         stall;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int           n_checks = 0;
  int           n_fail = 0;
  logic [63:0]  exp_q[$];

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .hilo_rd(hilo_rd), .hilo_wr(hilo_wr),
    .hilo_wr_sel(hilo_wr_sel), .hilo_wd(hilo_wd),
    .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: {hi, lo} for each op.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] p;
    logic signed [31:0] sx;
    logic signed [31:0] sy;
    sx = x;
    sy = y;
    case (o)
      2'd0: begin
        p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        return p;
      end
      2'd1: return {32'b0, x} * {32'b0, y};
      2'd2: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
        return {32'(sx % sy), 32'(sx / sy)};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Scoreboard: every done pops one expected {hi, lo}.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) chk_eq("unexpected_done", 64'd1, 64'd0);
      else chk_eq("hilo_result", {hi, lo}, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit push);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    if (push) exp_q.push_back(model(o, x, y));
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk_eq(tag, {63'd0, done}, 64'd1);
    tick();
  endtask

  // Issues an op and checks the busy window (cycles 1..33) and done at cycle 34.
  task automatic run_timed(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
    int bad;
    bad = 0;
    issue(o, x, y, 1'b1);
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      if (!busy || done) bad++;
      tick();
    end
    chk_eq({tag, "_busy_window"}, bad, 0);
    @(negedge clk);
    chk_eq({tag, "_done_c34"}, {62'd0, done, busy}, 64'd2);
    tick();
  endtask

  initial begin
    int bad;
    int ndone;
    logic [1:0]  ro;
    logic [31:0] rx;
    logic [31:0] ry;

    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk_eq("reset_hi", hi, 0);
    chk_eq("reset_lo", lo, 0);
    chk_eq("reset_ctl", {61'd0, busy, done, stall}, 0);
    tick();

    run_timed(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");

    issue(2'd0, 32'hFFFFFFFD, 32'd7, 1'b1);
    wait_done("mult_neg_done");

`ifdef MULDIV_DIV_EN
    issue(2'd2, 32'hFFFFFFF9, 32'd2, 1'b1);
    wait_done("div_neg_done");
    run_timed(2'd3, 32'd7, 32'd0, "divu_by0");
    issue(2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_done("div_min_done");
    issue(2'd2, 32'hFFFFFFF9, 32'd0, 1'b1);
    wait_done("div_neg_by0_done");
`else
    issue(2'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy || done) bad++;
      tick();
    end
    chk_eq("div_disabled_idle", bad, 0);
    chk_eq("div_disabled_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
`endif

    // MTHI / MTLO preload, then a cancelled multiply.
    hilo_wr = 1'b1; hilo_wr_sel = 1'b1; hilo_wd = 32'h11;
    tick();
    hilo_wr_sel = 1'b0; hilo_wd = 32'h22;
    tick();
    hilo_wr = 1'b0;
    @(negedge clk);
    chk_eq("mt_hilo", {hi, lo}, {32'h11, 32'h22});
    tick();
    issue(2'd1, 32'd5, 32'd6, 1'b0);
    repeat (9) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    @(negedge clk);
    chk_eq("cancel_busy", {63'd0, busy}, 0);
    chk_eq("cancel_hilo", {hi, lo}, {32'h11, 32'h22});
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      @(negedge clk);
      if (done) ndone++;
    end
    chk_eq("cancel_no_done", ndone, 0);
    tick();

    // Stall while busy with held MFHI and a held second start.
    issue(2'd1, 32'd3, 32'd4, 1'b1);
    tick();
    tick();
    hilo_rd = 1'b1; start = 1'b1; op = 2'd1; a = 32'd9; b = 32'd9;
    exp_q.push_back(model(2'd1, 32'd9, 32'd9));
    bad = 0;
    for (int c = 3; c <= 33; c++) begin
      @(negedge clk);
      if (!stall || done) bad++;
      tick();
    end
    chk_eq("stall_window", bad, 0);
    @(negedge clk);
    chk_eq("stall_release", {62'd0, stall, done}, 64'd1);
    tick();
    start = 1'b0;
    hilo_rd = 1'b0;
    @(negedge clk);
    chk_eq("b2b_accept", {63'd0, busy}, 1);
    wait_done("b2b_done");

    // Reset in the middle of an operation.
    issue(2'd0, 32'd100, 32'hFFFFFFFB, 1'b0);
    repeat (14) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hilo_rd = 1'b1;
    @(negedge clk);
    chk_eq("midrst_hilo", {hi, lo}, 0);
    chk_eq("midrst_ctl", {61'd0, busy, done, stall}, 0);
    hilo_rd = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      @(negedge clk);
      if (done) ndone++;
    end
    chk_eq("midrst_no_done", ndone, 0);
    tick();

    // Random operands.
    for (int i = 0; i < 8; i++) begin
`ifdef MULDIV_DIV_EN
      ro = 2'($urandom_range(0, 3));
`else
      ro = 2'($urandom_range(0, 1));
`endif
      rx = $urandom;
      ry = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
      issue(ro, rx, ry, 1'b1);
      wait_done("rand_done");
    end

    repeat (2) tick();
    chk_eq("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
